// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an LSB-first frame engine.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [7:0]       data_in,
  input  logic             wr_en,
  input  logic [1:0]       parity,
  input  logic             stop_sel,
  input  logic [23:0]      baudcontrol,
  output logic             uart_tx,
  output logic             tx_done,
  output logic             busy,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int               PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             overflow_q;

  // Frame engine
  state_e           state_q;
  logic [23:0]      baud_q;
  logic [23:0]      baud_cnt_q;
  logic [7:0]       data_q;
  logic [2:0]       bit_idx_q;
  logic             stop2_q;
  logic             stop_second_q;
  logic             uart_tx_q;
  logic             tx_done_q;
`ifdef UART_TX_PARITY_EN
  logic             par_en_q;
  logic             par_bit_q;
`else
  logic             unused_parity;
  assign unused_parity = ^parity;
`endif

  logic       wr_accept;
  logic       bit_end;
  logic       frame_end;
  logic       pop;
  logic [7:0] head;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign wr_accept = wr_en && !full;
  assign head      = mem_q[rd_ptr_q];

  assign bit_end   = (baud_cnt_q == '0);
  assign frame_end = (state_q == S_STOP) && bit_end && (!stop2_q || stop_second_q);
  // A new frame starts from IDLE, or straight out of the last stop bit.
  assign pop       = !empty && ((state_q == S_IDLE) || frame_end);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      overflow_q <= wr_en && full;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers is what discards its contents.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= S_IDLE;
      baud_q        <= '0;
      baud_cnt_q    <= '0;
      data_q        <= '0;
      bit_idx_q     <= '0;
      stop2_q       <= 1'b0;
      stop_second_q <= 1'b0;
      uart_tx_q     <= 1'b1;
      tx_done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
        end
        S_START: begin
          if (bit_end) begin
            state_q    <= S_DATA;
            baud_cnt_q <= baud_q;
            bit_idx_q  <= '0;
            uart_tx_q  <= data_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q - 24'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt_q <= baud_q;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              if (par_en_q) begin
                state_q   <= S_PARITY;
                uart_tx_q <= par_bit_q;
              end else
`endif
              begin
                state_q       <= S_STOP;
                uart_tx_q     <= 1'b1;
                stop_second_q <= 1'b0;
              end
            end else begin
              // data_q shifts right so bit 0 is always the bit on the line.
              bit_idx_q <= bit_idx_q + 3'd1;
              data_q    <= {1'b0, data_q[7:1]};
              uart_tx_q <= data_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 24'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            state_q       <= S_STOP;
            baud_cnt_q    <= baud_q;
            uart_tx_q     <= 1'b1;
            stop_second_q <= 1'b0;
          end else begin
            baud_cnt_q <= baud_cnt_q - 24'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            if (stop2_q && !stop_second_q) begin
              stop_second_q <= 1'b1;
              baud_cnt_q    <= baud_q;
            end else begin
              tx_done_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - 24'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      // Frame setup overrides the per-state updates above.
      if (pop) begin
        state_q    <= S_START;
        baud_q     <= baudcontrol;
        baud_cnt_q <= baudcontrol;
        data_q     <= head;
        stop2_q    <= stop_sel;
        uart_tx_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_q   <= (parity == 2'b01) || (parity == 2'b10);
        par_bit_q  <= (^head) ^ (parity == 2'b01);
`endif
      end
    end
  end

  assign uart_tx  = uart_tx_q;
  assign tx_done  = tx_done_q;
  assign busy     = (state_q != S_IDLE);
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed and randomized frames checked
// cycle by cycle against an expected line waveform built from the frame format.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             nrst;
  logic [7:0]       data_in;
  logic             wr_en;
  logic [1:0]       parity;
  logic             stop_sel;
  logic [23:0]      baudcontrol;
  logic             uart_tx;
  logic             tx_done;
  logic             busy;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wr_q[$];
  logic [7:0] sent_q[$];

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .parity      (parity),
    .stop_sel    (stop_sel),
    .baudcontrol (baudcontrol),
    .uart_tx     (uart_tx),
    .tx_done     (tx_done),
    .busy        (busy),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic bit par_enabled(input logic [1:0] p);
`ifdef UART_TX_PARITY_EN
    return (p == 2'b01) || (p == 2'b10);
`else
    return 1'b0;
`endif
  endfunction

  task automatic configure(input int baud, input logic [1:0] p, input logic s2);
    baudcontrol = 24'(baud);
    parity      = p;
    stop_sel    = s2;
  endtask

  // Entered at frame cycle `start` (0 = sample right after the start-bit edge);
  // returns at the sample point after the frame's final edge.
  task automatic check_frame(input logic [7:0] b, input int baud, input logic [1:0] p,
                             input logic s2, input int start);
    logic bits[$];
    int   len;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (par_enabled(p)) bits.push_back((p == 2'b10) ? ^b : ~^b);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    len = bits.size() * (baud + 1);
    for (int cyc = start; cyc < len; cyc++) begin
      check(uart_tx, bits[cyc / (baud + 1)], "line");
      check(busy, 1, "busy_in_frame");
      if (cyc > start) begin
        check(tx_done, 0, "tx_done_early");
        check(overflow, 0, "overflow_idle");
      end
      step();
    end
    check(tx_done, 1, "tx_done_end");
  endtask

  task automatic send_single(input logic [7:0] b, input int baud, input logic [1:0] p,
                             input logic s2);
    configure(baud, p, s2);
    data_in = b;
    wr_en   = 1'b1;
    step();
    wr_en = 1'b0;
    check(empty, 0, "lat_empty");
    check(count, 1, "lat_count");
    check(uart_tx, 1, "lat_line_idle");
    step();
    check(count, 0, "pop_count");
    check(empty, 1, "pop_empty");
    check_frame(b, baud, p, s2, 0);
    check(busy, 0, "busy_after");
    check(uart_tx, 1, "line_after");
  endtask

  // Writes wr_q on consecutive cycles from idle. The first byte pops one edge
  // after its write and no other frame ends during the burst, so occupancy is
  // 1,1,2,3,... capped at DEPTH; writes beyond that are dropped.
  task automatic fill();
    int exp_cnt;
    sent_q.delete();
    for (int i = 0; i < wr_q.size(); i++) begin
      data_in = wr_q[i];
      wr_en   = 1'b1;
      step();
      exp_cnt = (i == 0) ? 1 : ((i > DEPTH) ? DEPTH : i);
      check(count, exp_cnt, "burst_count");
      check(full, exp_cnt == DEPTH, "burst_full");
      check(overflow, i > DEPTH, "burst_overflow");
      if (i <= DEPTH) sent_q.push_back(wr_q[i]);
    end
    wr_en = 1'b0;
  endtask

  task automatic check_burst(input int baud, input logic [1:0] p, input logic s2);
    check_frame(sent_q[0], baud, p, s2, wr_q.size() - 2);
    for (int k = 1; k < sent_q.size(); k++) check_frame(sent_q[k], baud, p, s2, 0);
    check(busy, 0, "burst_busy_after");
    check(count, 0, "burst_count_after");
    check(uart_tx, 1, "burst_line_after");
  endtask

  initial begin
    int baud;
    logic [1:0] p;
    logic s2;
    int quiet_bad;

    nrst    = 1'b0;
    wr_en   = 1'b0;
    data_in = 8'h00;
    configure(0, 2'b00, 1'b0);
    step();
    check(uart_tx, 1, "rst_uart_tx");
    check(tx_done, 0, "rst_tx_done");
    check(busy, 0, "rst_busy");
    check(empty, 1, "rst_empty");
    check(full, 0, "rst_full");
    check(count, 0, "rst_count");
    check(overflow, 0, "rst_overflow");
    step();
    nrst = 1'b1;
    step();

    // Basic 8N1 frame, 4 cycles per bit.
    send_single(8'h55, 3, 2'b00, 1'b0);

    // Parity modes (even, then odd); plain 8N1 when parity is not built.
    send_single(8'h55, 1, 2'b10, 1'b0);
    send_single(8'h55, 1, 2'b01, 1'b0);

    // Two stop bits at one cycle per bit, back-to-back frames.
    configure(0, 2'b00, 1'b1);
    wr_q = '{8'hA3, 8'h0F};
    fill();
    check_burst(0, 2'b00, 1'b1);

    // Overflow: 18 writes into a 16-entry buffer while idle.
    configure(3, 2'b00, 1'b0);
    wr_q.delete();
    for (int i = 0; i < 18; i++) wr_q.push_back(8'(i));
    fill();
    check(sent_q.size(), 17, "ovf_accepted");
    check_burst(3, 2'b00, 1'b0);

    // Reconfiguration during a frame only affects the next frame.
    configure(3, 2'b00, 1'b0);
    wr_q = '{8'h3C, 8'hC5};
    fill();
    baudcontrol = 24'd7;
    stop_sel    = 1'b1;
    data_in     = 8'hFF;
    check_frame(8'h3C, 3, 2'b00, 1'b0, 0);
    check_frame(8'hC5, 7, 2'b00, 1'b1, 0);
    check(busy, 0, "reconf_busy_after");

    // Randomized single frames.
    for (int r = 0; r < 6; r++) begin
      baud = $urandom_range(0, 4);
      p    = 2'($urandom_range(0, 3));
      s2   = 1'($urandom_range(0, 1));
      send_single(8'($urandom), baud, p, s2);
    end

    // Randomized short bursts.
    for (int r = 0; r < 3; r++) begin
      baud = $urandom_range(0, 3);
      p    = 2'($urandom_range(0, 3));
      s2   = 1'($urandom_range(0, 1));
      configure(baud, p, s2);
      wr_q.delete();
      for (int i = 0; i < int'($urandom_range(2, 5)); i++) wr_q.push_back(8'($urandom));
      fill();
      check_burst(baud, p, s2);
    end

    // Reset during data bit 3 with five bytes queued.
    configure(3, 2'b00, 1'b0);
    wr_q = '{8'h96, 8'h11, 8'h22, 8'h33, 8'h44};
    fill();
    for (int cyc = 3; cyc < 17; cyc++) step();
    check(uart_tx, wr_q[0][3], "pre_reset_bit3");
    nrst = 1'b0;
    step();
    check(uart_tx, 1, "mid_rst_uart_tx");
    check(count, 0, "mid_rst_count");
    check(busy, 0, "mid_rst_busy");
    check(empty, 1, "mid_rst_empty");
    check(tx_done, 0, "mid_rst_tx_done");
    nrst = 1'b1;
    quiet_bad = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      step();
      if (uart_tx !== 1'b1 || tx_done !== 1'b0 || busy !== 1'b0) quiet_bad++;
    end
    check(quiet_bad, 0, "no_frames_after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
